sram_controller: RTL and testbench

- Responder for the MEM stage's data-memory request interface: accepts 32-bit word read/write requests (rd_en/wr_en, address, write data).
- Serves each request as two 16-bit half-word accesses on an external asynchronous SRAM.
- Holds ready low while busy so the core can freeze the pipeline.
- Sits between the MEM stage and the board SRAM pins, in the core's clock domain.

---
 rtl/sram_controller_if.sv | 33 +++
 rtl/sram_controller.sv | 152 +++++++++++++++
 tb/tb_sram_controller.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// Connection bundle between the MEM-stage requester, the SRAM controller and the board SRAM pins.
// "master" is the environment side (core plus SRAM device); "slave" is the controller.
interface sram_controller_if #(
    parameter int SRAM_AW = 18
);
    logic               wr_en;
    logic               rd_en;
    logic [31:0]        address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic               sram_dq_oe;
    logic [15:0]        sram_dq_in;
    logic               sram_we_n;
    logic               sram_oe_n;
    logic               sram_ce_n;
    logic               sram_ub_n;
    logic               sram_lb_n;

    modport master (
        output wr_en, rd_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
               sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
    );

    modport slave (
        input  wr_en, rd_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
               sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
    );
endinterface

// File: rtl/sram_controller.sv
// Serves 32-bit MEM-stage loads/stores as two 16-bit half-word accesses on an asynchronous SRAM,
// holding ready low while the access is in flight so the pipeline can freeze.
module sram_controller #(
    parameter int DATA_BASE = 1024,
    parameter int WAIT_CYC  = 2,
    parameter int SRAM_AW   = 18
) (
    input  logic             clk,
    input  logic             rst,
    sram_controller_if.slave bus
);
    localparam int            CW       = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYC - 1);
    localparam int            WW       = SRAM_AW - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_is_wr;
    logic [WW-1:0]      r_word;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic [SRAM_AW-1:0] r_addr;
    logic [15:0]        r_dq_out;
    logic               r_dq_oe;
    logic               r_we_n;
    logic               r_oe_n;
    logic               r_ce_n;

    logic               w_req;
    logic [31:0]        w_offset;
    logic [WW-1:0]      w_word;
    logic               w_last;
    logic               w_ready;
    logic               w_unused_bits;

    // Request decode, word-address mapping and the IDLE-time combinational ready
    always_comb begin
        w_req         = bus.wr_en | bus.rd_en;
        w_offset      = bus.address - 32'(DATA_BASE);
        w_word        = w_offset[WW+1:2];
        w_last        = (r_cnt == CNT_LAST);
        w_unused_bits = ^{w_offset[1:0], w_offset[31:WW+2]};
        case (r_state)
            S_IDLE:  w_ready = ~w_req;
            S_DONE:  w_ready = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    // Access sequencer: state, wait counter, latched request and registered SRAM pins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_wr  <= 1'b0;
            r_word   <= '0;
            r_wdata  <= 32'h0000_0000;
            r_rdata  <= 32'h0000_0000;
            r_addr   <= '0;
            r_dq_out <= 16'h0000;
            r_dq_oe  <= 1'b0;
            r_we_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_ce_n   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_req) begin
                        // A simultaneous read and write request is served as a write
                        r_state  <= S_LOW;
                        r_is_wr  <= bus.wr_en;
                        r_word   <= w_word;
                        r_wdata  <= bus.write_data;
                        r_addr   <= {w_word, 1'b0};
                        r_ce_n   <= 1'b0;
                        r_we_n   <= ~bus.wr_en;
                        r_oe_n   <= bus.wr_en;
                        r_dq_oe  <= bus.wr_en;
                        r_dq_out <= bus.wr_en ? bus.write_data[15:0] : 16'h0000;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOW: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_HIGH;
                        r_addr  <= {r_word, 1'b1};
                        if (r_is_wr) begin
                            r_dq_out <= r_wdata[31:16];
                        end else begin
                            r_rdata[15:0] <= bus.sram_dq_in;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_HIGH: begin
                    if (w_last) begin
                        r_cnt    <= '0;
                        r_state  <= S_DONE;
                        r_ce_n   <= 1'b1;
                        r_we_n   <= 1'b1;
                        r_oe_n   <= 1'b1;
                        r_dq_oe  <= 1'b0;
                        r_dq_out <= 16'h0000;
                        if (!r_is_wr) begin
                            r_rdata[31:16] <= bus.sram_dq_in;
                        end else begin
                            r_rdata <= r_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_cnt    <= '0;
                    r_ce_n   <= 1'b1;
                    r_we_n   <= 1'b1;
                    r_oe_n   <= 1'b1;
                    r_dq_oe  <= 1'b0;
                    r_dq_out <= 16'h0000;
                end
            endcase
        end
    end

    assign bus.ready       = w_ready;
    assign bus.read_data   = r_rdata;
    assign bus.sram_addr   = r_addr;
    assign bus.sram_dq_out = r_dq_out;
    assign bus.sram_dq_oe  = r_dq_oe;
    assign bus.sram_we_n   = r_we_n;
    assign bus.sram_oe_n   = r_oe_n;
    assign bus.sram_ce_n   = r_ce_n;
    // Both byte lanes follow chip enable: only whole half-words are ever transferred
    assign bus.sram_ub_n   = r_ce_n;
    assign bus.sram_lb_n   = r_ce_n;
endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: directed plan cases plus randomized accesses
// compared against a word-level reference memory and an external half-word SRAM device model.
module tb_sram_controller;
    localparam int DATA_BASE = 1024;
    localparam int WAIT_CYC  = 2;
    localparam int SRAM_AW   = 18;
    localparam int WORDS     = 1 << (SRAM_AW - 1);

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ce_edges = 0;

    logic [15:0] sram_mem [0:(1<<SRAM_AW)-1];
    logic [31:0] ref_words [int];
    logic [31:0] exp_rdata;

    sram_controller_if #(.SRAM_AW(SRAM_AW)) bus ();

    sram_controller #(
        .DATA_BASE(DATA_BASE),
        .WAIT_CYC (WAIT_CYC),
        .SRAM_AW  (SRAM_AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM device: read data whenever selected with output enable, write on strobe
    assign bus.sram_dq_in = (!bus.sram_ce_n && !bus.sram_oe_n) ? sram_mem[bus.sram_addr] : 16'h0000;

    always @(posedge clk) begin
        if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe) sram_mem[bus.sram_addr] <= bus.sram_dq_out;
    end

    always @(bus.sram_ce_n) ce_edges++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_ref(input int w);
        return ref_words.exists(w) ? ref_words[w] : 32'h0000_0000;
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - 32'(DATA_BASE);
        return int'((off / 32'd4) % 32'(WORDS));
    endfunction

    // One complete access; keep=1 leaves the request asserted through DONE for back-to-back use
    task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                              input logic [31:0] data, input bit keep);
        int word;
        int hi;
        bit is_wr;
        word  = word_of(addr);
        is_wr = wr;
        @(posedge clk); #1;
        bus.wr_en = wr; bus.rd_en = rd; bus.address = addr; bus.write_data = data;
        @(negedge clk);
        check("req_ready", bus.ready, 32'd0);
        check("req_ce_n", bus.sram_ce_n, 32'd1);
        if (is_wr) ref_words[word] = data;
        else exp_rdata = rd_ref(word);
        for (int c = 1; c <= 2*WAIT_CYC+1; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                bus.address = $urandom; bus.write_data = $urandom;
            end
            if (c == 2*WAIT_CYC+1 && !keep) begin
                bus.wr_en = 1'b0; bus.rd_en = 1'b0;
            end
            @(negedge clk);
            if (c <= 2*WAIT_CYC) begin
                hi = (c > WAIT_CYC) ? 1 : 0;
                check("acc_ready", bus.ready, 32'd0);
                check("acc_ce_n", bus.sram_ce_n, 32'd0);
                check("acc_ub_lb", {bus.sram_ub_n, bus.sram_lb_n}, 32'd0);
                check("acc_addr", bus.sram_addr, word*2 + hi);
                check("acc_we_n", bus.sram_we_n, is_wr ? 32'd0 : 32'd1);
                check("acc_oe_n", bus.sram_oe_n, is_wr ? 32'd1 : 32'd0);
                check("acc_dq_oe", bus.sram_dq_oe, is_wr ? 32'd1 : 32'd0);
                if (is_wr) check("acc_dq_out", bus.sram_dq_out, hi ? data[31:16] : data[15:0]);
            end else begin
                check("done_ready", bus.ready, 32'd1);
                check("done_strobes", {bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n,
                                       bus.sram_ub_n, bus.sram_lb_n, bus.sram_dq_oe}, 32'h3E);
                check("done_rdata", bus.read_data, exp_rdata);
            end
        end
        if (!keep) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("post_ready", bus.ready, 32'd1);
            check("post_ce_n", bus.sram_ce_n, 32'd1);
            check("post_rdata", bus.read_data, exp_rdata);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] old;
        logic [31:0] a;
        int op;
        for (int i = 0; i < (1 << SRAM_AW); i++) sram_mem[i] = 16'h0000;
        rst = 1'b0;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = 32'h0; bus.write_data = 32'h0;
        exp_rdata = 32'h0000_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", bus.ready, 32'd1);
        check("rst_strobes", {bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n,
                              bus.sram_ub_n, bus.sram_lb_n}, 32'h1F);
        check("rst_addr", bus.sram_addr, 32'd0);
        check("rst_dq", {15'd0, bus.sram_dq_oe, bus.sram_dq_out}, 32'd0);
        check("rst_rdata", bus.read_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Directed: basic write then read-back
        run_access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 1'b0);
        check("dev_low", sram_mem[0], 32'h0000_BEEF);
        check("dev_high", sram_mem[1], 32'h0000_DEAD);
        run_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);

        // Address wrap at the top of the SRAM and below DATA_BASE
        run_access(1'b1, 1'b0, 32'd1024 + 32'd4 * 32'h1FFFF, 32'h1234_5678, 1'b0);
        run_access(1'b0, 1'b1, 32'd1020, 32'h0, 1'b0);
        check("wrap_rdata", bus.read_data, 32'h1234_5678);

        // Simultaneous read and write is a write; read_data must stay put
        run_access(1'b1, 1'b1, 32'd1028, 32'hCAFE_F00D, 1'b0);
        check("both_rdata", bus.read_data, 32'h1234_5678);
        run_access(1'b0, 1'b1, 32'd1029, 32'h0, 1'b0);

        // Back-to-back reads with the request held through DONE
        ce_edges = 0;
        run_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1);
        run_access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        check("b2b_ce_edges", ce_edges, 32'd4);

        // Randomized mix over a small window plus occasional below-base wraps
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 2);
            a  = 32'(DATA_BASE) + 32'd4 * 32'($urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 32'(DATA_BASE) - 32'd4 * 32'($urandom_range(1, 4));
            d  = $urandom;
            run_access(op != 1, op != 0, a, d, 1'b0);
        end

        // Reset during the first HIGH cycle of a write
        old = rd_ref(5);
        d   = ~old;
        @(posedge clk); #1;
        bus.wr_en = 1'b1; bus.address = 32'd1024 + 32'd20; bus.write_data = d;
        repeat (WAIT_CYC + 1) @(posedge clk);
        #1;
        check("abort_pre_addr", bus.sram_addr, 32'd11);
        #2;
        rst = 1'b0; bus.wr_en = 1'b0;
        #1;
        check("abort_strobes", {bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n,
                                bus.sram_ub_n, bus.sram_lb_n, bus.sram_dq_oe}, 32'h3E);
        check("abort_ready", bus.ready, 32'd1);
        check("abort_rdata", bus.read_data, 32'd0);
        ref_words[5] = {old[31:16], d[15:0]};
        exp_rdata = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_idle", {bus.ready, bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n}, 32'hF);
        end
        run_access(1'b0, 1'b1, 32'd1024 + 32'd20, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
